// File: rtl/fetch_stage.sv
// Instruction-fetch stage with PC register and IF/ID pipeline register.
// Feeds Decode and exposes op/funct3/funct7b5 slices to the controller.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] PCF,
  input  logic [31:0] InstrF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [6:0]  opD,
  output logic [2:0]  funct3D,
  output logic        funct7b5D
);

  logic [31:0] r_pc;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc4_d;
  logic        r_valid_d;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic        w_unused_tgt;

  // Target low bits are dropped so the fetch address stays word aligned.
  assign w_unused_tgt = ^PCTargetE[1:0];

  // Sequential or redirected next PC; PC+4 wraps silently.
  always_comb begin
    w_pc_plus4 = r_pc + 32'd4;
    w_pc_next  = w_pc_plus4;
    if (PCSrcE)
      w_pc_next = {PCTargetE[31:2], 2'b00};
  end

  // PC register: reset, then stall hold, then advance.
  always_ff @(posedge clk) begin
    if (reset)
      r_pc <= RESET_PC;
    else if (!StallF)
      r_pc <= w_pc_next;
  end

  // IF/ID register: reset/flush inject a NOP, stall holds, else capture.
  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= 32'd0;
      r_pc4_d   <= 32'd0;
      r_valid_d <= 1'b0;
    end else if (!StallD) begin
      r_instr_d <= InstrF;
      r_pc_d    <= r_pc;
      r_pc4_d   <= w_pc_plus4;
      r_valid_d <= 1'b1;
    end
  end

  assign PCF       = r_pc;
  assign InstrD    = r_instr_d;
  assign PCD       = r_pc_d;
  assign PCPlus4D  = r_pc4_d;
  assign ValidD    = r_valid_d;
  assign opD       = r_instr_d[6:0];
  assign funct3D   = r_instr_d[14:12];
  assign funct7b5D = r_instr_d[30];

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage RISC-V core. Holds the PC, drives the instruction-memory address, selects sequential or redirected next-PC, and registers the fetched instruction into Decode. Its Decode-side outputs supply `op`, `funct3` and `funct7b5` to the controller, so it is the producing end of the controller's instruction-field interface. Stall and flush come from the hazard unit; the redirect comes from Execute.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0013, instruction injected on flush or reset (`addi x0,x0,0`).

- clk  input  1  core clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- StallF  input  1  hold the PC register.
- StallD  input  1  hold the IF/ID register.
- FlushD  input  1  load NOP into the IF/ID register.
- PCSrcE  input  1  redirect: next PC = PCTargetE.
- PCTargetE  input  32  branch/jump target from Execute.
- PCF  output  32  instruction-memory address (registered).
- InstrF  input  32  instruction-memory read data; combinational from PCF.
- InstrD  output  32  registered instruction in Decode.
- PCD  output  32  PC of InstrD.
- PCPlus4D  output  32  PCD + 4.
- ValidD  output  1  InstrD is a real fetched instruction, not reset/flush filler.
- opD  output  7  InstrD[6:0], to the controller `op`.
- funct3D  output  3  InstrD[14:12], to the controller `funct3`.
- funct7b5D  output  1  InstrD[30], to the controller `funct7b5`.

## Operation
- PCPlus4F = PCF + 4, modulo 2^32. Wrap from 32'hFFFF_FFFC to 0 is legal and not flagged.
- PCNextF = PCSrcE ? {PCTargetE[31:2], 2'b00} : PCPlus4F. Target bits [1:0] are discarded, so PCF[1:0] is always 0.
- PC register priority, per rising edge:
  - reset: PCF <= RESET_PC.
  - else StallF: PCF holds. StallF wins over PCSrcE; the hazard unit never asserts both.
  - else PCF <= PCNextF.
- IF/ID register priority, per rising edge:
  - reset: InstrD <= NOP_INSTR, PCD <= 0, PCPlus4D <= 0, ValidD <= 0.
  - else FlushD: same values as reset. FlushD wins over StallD.
  - else StallD: all IF/ID fields hold.
  - else InstrD <= InstrF, PCD <= PCF, PCPlus4D <= PCPlus4F, ValidD <= 1.
- opD, funct3D and funct7b5D are pure combinational slices of InstrD and carry no extra register.
- No internal state besides the PC and IF/ID registers. The hazard unit's stall/flush pairing defines the pipeline state.

## Timing
- Reset values: PCF = RESET_PC, InstrD = NOP_INSTR, opD = 7'h13, funct3D = 0, funct7b5D = 0, PCD = 0, PCPlus4D = 0, ValidD = 0.
- First edge with reset low: InstrD = mem[RESET_PC], PCD = RESET_PC, ValidD = 1, PCF = RESET_PC+4.
- Fetch-to-Decode latency is 1 cycle. InstrF must settle within the cycle in which PCF is stable.
- Redirect: PCSrcE high in cycle N gives PCF = target in N+1. The hazard unit asserts FlushD in N, so Decode holds NOP in N+1 and the target instruction in N+2.
- Stall with StallF=StallD=1 for k cycles: PCF and all D outputs are frozen for k cycles, then advance normally with no instruction lost or duplicated.
- Reset asserted mid-stall or mid-redirect: reset values on the next edge, and pending PCSrcE and stall inputs are ignored.
- No handshakes and no combinational path from inputs to registered outputs, except InstrF to nothing in the same cycle.

## Test plan
- Reset then free-run, memory word i = 32'h0010_0093 + (i<<20), RESET_PC=0 -> PCF sequence 0,4,8,12. InstrD lags by 1 cycle. ValidD goes 0 then 1. opD = 7'h13 throughout.
- Redirect: PCSrcE=1 with PCTargetE=32'h0000_0103 while PCF=8, FlushD=1 in the same cycle -> next PCF = 32'h100, InstrD = NOP with ValidD=0, then InstrD = mem[0x100] with PCD = 0x100.
- Stall: StallF=StallD=1 for 3 cycles while PCF=0x10 and PCD=0xC -> all outputs constant for 3 cycles, then PCD = 0x10 and PCF = 0x14.
- Priority: FlushD=1 and StallD=1 together -> InstrD = NOP, ValidD = 0. StallF=1 and PCSrcE=1 together -> PCF unchanged.
- Wrap: force PCF to 32'hFFFF_FFFC, free-run -> PCF = 0 and PCPlus4D = 0 for that instruction.
- Reset mid-operation: assert reset for 1 cycle while PCSrcE=1 -> PCF = RESET_PC and all D outputs at reset values on the next edge.
